// File: rtl/ct_accum_serial.sv
// Slot-serial ciphertext accumulator: sums a stream of (A,B) terms mod Q_MOD with one adder per component.
// Optional term counter port out_terms is enabled by defining CT_ACCUM_CNT_EN.
module ct_accum_serial #(
    parameter int N_SLOTS_L = 8,
    parameter int W_BITS_L  = 16,
    parameter int Q_MOD     = 7710
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [1:0][N_SLOTS_L-1:0][W_BITS_L-1:0] in_ct,
    input  logic                                    in_last,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [1:0][N_SLOTS_L-1:0][W_BITS_L-1:0] out_ct,
    output logic                                    busy
`ifdef CT_ACCUM_CNT_EN
    ,
    output logic [15:0]                             out_terms
`endif
);

    localparam int IDX_W = $clog2(N_SLOTS_L);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_SLOTS_L - 1);
    localparam logic [W_BITS_L:0] QP_X     = (W_BITS_L + 1)'(Q_MOD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    typedef logic [1:0][N_SLOTS_L-1:0][W_BITS_L-1:0] ct_t;

    // Sum in W+1 bits so the carry is never lost, then fold once.
    function automatic logic [W_BITS_L-1:0] mod_add(input logic [W_BITS_L-1:0] a,
                                                    input logic [W_BITS_L-1:0] b);
        logic [W_BITS_L:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= QP_X) begin
            s = s - QP_X;
        end
        return s[W_BITS_L-1:0];
    endfunction

    state_t            r_state;
    state_t            w_state_next;
    ct_t               r_acc;
    ct_t               r_op;
    ct_t               r_out_ct;
    ct_t               w_acc_next;
    logic              r_acc_empty;
    logic [IDX_W-1:0]  r_idx;
    logic              r_last_q;
    logic              w_in_fire;
    logic              w_out_fire;

    assign w_in_fire  = in_valid && (r_state == S_IDLE);
    assign w_out_fire = out_ready && (r_state == S_OUT);

    // Accumulator with the current slot of both components replaced by its modular sum.
    always_comb begin
        w_acc_next = r_acc;
        for (int c = 0; c < 2; c++) begin
            w_acc_next[c][r_idx] = mod_add(r_acc[c][r_idx], r_op[c][r_idx]);
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (r_acc_empty) begin
                        w_state_next = in_last ? S_OUT : S_IDLE;
                    end else begin
                        w_state_next = S_ADD;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_ADD: begin
                if (r_idx == IDX_LAST) begin
                    w_state_next = r_last_q ? S_OUT : S_IDLE;
                end else begin
                    w_state_next = S_ADD;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_OUT;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: load, per-slot add, and output capture. out_ct is only
    // written with a finished sum so it never exposes a partial ADD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_op        <= '0;
            r_out_ct    <= '0;
            r_acc_empty <= 1'b1;
            r_idx       <= '0;
            r_last_q    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (r_acc_empty) begin
                            r_acc       <= in_ct;
                            r_acc_empty <= 1'b0;
                            if (in_last) begin
                                r_out_ct <= in_ct;
                            end
                        end else begin
                            r_op     <= in_ct;
                            r_last_q <= in_last;
                            r_idx    <= '0;
                        end
                    end
                end
                S_ADD: begin
                    r_acc <= w_acc_next;
                    if (r_idx == IDX_LAST) begin
                        if (r_last_q) begin
                            r_out_ct <= w_acc_next;
                        end
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_acc       <= '0;
                        r_acc_empty <= 1'b1;
                        r_out_ct    <= '0;
                    end
                end
                default: begin
                    r_acc_empty <= 1'b1;
                end
            endcase
        end
    end

`ifdef CT_ACCUM_CNT_EN
    logic [15:0] r_terms;

    // Terms in the current sum; sticks at all-ones while accumulation carries on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_terms <= 16'd0;
        end else if (w_out_fire) begin
            r_terms <= 16'd0;
        end else if (w_in_fire && (r_terms != 16'hFFFF)) begin
            r_terms <= r_terms + 16'd1;
        end
    end

    assign out_terms = r_terms;
`else
    logic w_unused_fire;
    assign w_unused_fire = w_in_fire ^ w_out_fire;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign out_ct    = r_out_ct;
    assign busy      = (r_state != S_IDLE) || !r_acc_empty;

endmodule

// File: tb/tb_ct_accum_serial.sv
// Directed plus randomized bench for ct_accum_serial (N=8, W=16, QP=7710); the
// reference keeps raw integer sums per slot and reduces them mod QP only when comparing.
module tb_ct_accum_serial;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int QP = 7710;

    typedef logic [1:0][N-1:0][W-1:0] ct_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    ct_t  in_ct = '0;
    logic in_last = 1'b0;
    logic out_valid;
    logic out_ready = 1'b0;
    ct_t  out_ct;
    logic busy;
`ifdef CT_ACCUM_CNT_EN
    logic [15:0] out_terms;
`endif

    ct_accum_serial #(.N_SLOTS_L(N), .W_BITS_L(W), .Q_MOD(QP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ct     (in_ct),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ct    (out_ct),
        .busy      (busy)
`ifdef CT_ACCUM_CNT_EN
        ,
        .out_terms (out_terms)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int msum[2][N];
    int mcnt = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++)
            for (int s = 0; s < N; s++) msum[c][s] = 0;
        mcnt = 0;
    endtask

    function automatic ct_t model_expect();
        ct_t e;
        for (int c = 0; c < 2; c++)
            for (int s = 0; s < N; s++) e[c][s] = W'(msum[c][s] % QP);
        return e;
    endfunction

    function automatic ct_t rand_ct();
        ct_t t;
        for (int c = 0; c < 2; c++)
            for (int s = 0; s < N; s++) t[c][s] = W'($urandom_range(QP - 1, 0));
        return t;
    endfunction

    function automatic ct_t fill_ct(input int v);
        ct_t t;
        for (int c = 0; c < 2; c++)
            for (int s = 0; s < N; s++) t[c][s] = W'(v);
        return t;
    endfunction

    // Drive a term, hold it until accepted, then optionally check the add latency and result.
    task automatic send(input ct_t t, input logic last, input bit post);
        int  g;
        bit  was_empty;
        @(negedge clk);
        in_valid = 1'b1;
        in_ct    = t;
        in_last  = last;
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("ready_timeout", (g < 100), 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        was_empty = (mcnt == 0);
        for (int c = 0; c < 2; c++)
            for (int s = 0; s < N; s++) msum[c][s] += int'(t[c][s]);
        mcnt++;
        if (post) begin
            if (!was_empty) begin
                for (int k = 0; k < N; k++) begin
                    chk("add_in_ready", in_ready, 1'b0);
                    chk("add_out_valid", out_valid, 1'b0);
                    @(posedge clk);
                    #1;
                end
            end
            if (last) begin
                chk("out_valid", out_valid, 1'b1);
                chk("out_ct", out_ct, model_expect());
`ifdef CT_ACCUM_CNT_EN
                chk("out_terms", out_terms, 16'(mcnt));
`endif
            end else begin
                chk("ready_again", in_ready, 1'b1);
                chk("busy_partial", busy, 1'b1);
            end
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drain_out_valid", out_valid, 1'b0);
        chk("drain_in_ready", in_ready, 1'b1);
        chk("drain_busy", busy, 1'b0);
        model_clear();
`ifdef CT_ACCUM_CNT_EN
        chk("drain_terms", out_terms, 16'd0);
`endif
    endtask

    initial begin
        ct_t t1, t2, e;
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_ct", out_ct, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single term passes straight through
        t1 = rand_ct();
        t1[0][0] = 16'd1429;
        send(t1, 1'b1, 1'b1);
        chk("single_equal", out_ct, t1);
        drain();

        // Two-term sum with known slot values
        t1 = rand_ct();
        t1[0][0] = 16'd1429; t1[0][1] = 16'd4717; t1[1][0] = 16'd7531;
        t2 = rand_ct();
        t2[0][0] = 16'd1081; t2[0][1] = 16'd592;  t2[1][0] = 16'd1577;
        send(t1, 1'b0, 1'b1);
        send(t2, 1'b1, 1'b1);
        chk("two_a0", out_ct[0][0], 16'd2510);
        chk("two_a1", out_ct[0][1], 16'd5309);
        chk("two_b0", out_ct[1][0], 16'd1398);
        drain();

        // Three terms
        send(t1, 1'b0, 1'b1);
        send(t2, 1'b0, 1'b1);
        send(t2, 1'b1, 1'b1);
        chk("three_a0", out_ct[0][0], 16'd3591);
        chk("three_b0", out_ct[1][0], 16'd2975);
        drain();

        // Wrap-around boundaries
        send(fill_ct(QP - 1), 1'b0, 1'b1);
        send(fill_ct(1), 1'b1, 1'b1);
        chk("wrap_zero", out_ct, fill_ct(0));
        drain();
        send(fill_ct(QP - 1), 1'b0, 1'b1);
        send(fill_ct(QP - 1), 1'b1, 1'b1);
        chk("wrap_max", out_ct, fill_ct(QP - 2));
        drain();

        // Output back-pressure
        send(rand_ct(), 1'b0, 1'b1);
        send(rand_ct(), 1'b1, 1'b1);
        e = model_expect();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("hold_out_ct", out_ct, e);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_out_valid", out_valid, 1'b1);
        end
        drain();
        t1 = rand_ct();
        send(t1, 1'b1, 1'b1);
        chk("after_hold_fresh", out_ct, t1);
        drain();

        // Reset in the middle of an ADD pass
        send(rand_ct(), 1'b0, 1'b1);
        send(rand_ct(), 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        rst_n = 1'b1;
        model_clear();
        t1 = rand_ct();
        send(t1, 1'b1, 1'b1);
        chk("midrst_fresh", out_ct, t1);
        drain();

        // Randomized sums with random output stalls
        for (int r = 0; r < 15; r++) begin
            int nt;
            nt = $urandom_range(4, 1);
            for (int k = 0; k < nt; k++) begin
                send(rand_ct(), (k == nt - 1), 1'b1);
                repeat ($urandom_range(2, 0)) @(posedge clk);
            end
            #1;
            chk("rand_stall_ct", out_ct, model_expect());
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
